// File: rtl/mult8x8_controller_pkg.sv
// Shared constants and encodings for the sequential 8x8 multiplier:
// operand widths, controller states, nibble-select and shift-select codes.
package mult8x8_controller_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned DW      = 2 * NIB_W;
    localparam int unsigned PROD_W  = 2 * DW;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned SHIFT_W = 2;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'b000,
        ST_LSB       = 3'b001,
        ST_MID       = 3'b010,
        ST_MSB       = 3'b011,
        ST_CALC_DONE = 3'b100,
        ST_ERR       = 3'b101
    } state_e;

    // input_sel[0] picks the a nibble, input_sel[1] the b nibble (0 lo, 1 hi)
    localparam logic [SEL_W-1:0] SEL_ALO_BLO = 2'b00;
    localparam logic [SEL_W-1:0] SEL_AHI_BLO = 2'b01;
    localparam logic [SEL_W-1:0] SEL_ALO_BHI = 2'b10;
    localparam logic [SEL_W-1:0] SEL_AHI_BHI = 2'b11;

    localparam logic [SHIFT_W-1:0] SHIFT_0 = 2'b00;
    localparam logic [SHIFT_W-1:0] SHIFT_4 = 2'b01;
    localparam logic [SHIFT_W-1:0] SHIFT_8 = 2'b10;

endpackage

// File: rtl/mult8x8_controller_if.sv
// Control bundle between the start source, the multiplier controller and the datapath.
interface mult8x8_controller_if;
    import mult8x8_controller_pkg::*;

    logic                 start;
    logic [SEL_W-1:0]     input_sel;
    logic [SHIFT_W-1:0]   shift_sel;
    logic                 clk_ena;
    logic                 sclr_n;
    logic                 done;
    logic [STATE_W-1:0]   state_out;

    modport master (
        output start,
        input  input_sel, shift_sel, clk_ena, sclr_n, done, state_out
    );

    modport slave (
        input  start,
        output input_sel, shift_sel, clk_ena, sclr_n, done, state_out
    );

endinterface

// File: rtl/mult8x8_controller_counter.sv
// 2-bit step counter with synchronous clear/enable; sequences the two MID cycles.
module mult8x8_controller_counter
    import mult8x8_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mult8x8_controller.sv
// Sequencing FSM for the 8x8 multiplier: walks the four nibble partial products
// through the datapath and reports completion / error state for the display.
module mult8x8_controller
    import mult8x8_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mult8x8_controller_if.slave  bus
);

    state_e             state_d;
    state_e             state_q;
    logic [CNT_W-1:0]   count;
    logic               cnt_clr;
    logic               cnt_en;
    logic               start_v;

    logic [SEL_W-1:0]   sel_c;
    logic [SHIFT_W-1:0] shift_c;
    logic               clk_ena_c;
    logic               sclr_n_c;
    logic               done_c;

    // A start coincident with reset must not leak a clear onto the datapath
    assign start_v = bus.start & ~reset;

    mult8x8_controller_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    always_comb begin
        state_d   = state_q;
        sel_c     = SEL_ALO_BLO;
        shift_c   = SHIFT_0;
        clk_ena_c = 1'b0;
        sclr_n_c  = 1'b1;
        done_c    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_ERR, ST_CALC_DONE: begin
                done_c = (state_q == ST_CALC_DONE);
                if (start_v) begin
                    // clear wins over load in the accumulator; enable is asserted anyway
                    sclr_n_c  = 1'b0;
                    clk_ena_c = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = ST_LSB;
                end
            end
            ST_LSB: begin
                if (start_v) begin
                    state_d = ST_ERR;
                end else begin
                    clk_ena_c = 1'b1;
                    state_d   = ST_MID;
                end
            end
            ST_MID: begin
                sel_c   = (count == CNT_W'(0)) ? SEL_AHI_BLO : SEL_ALO_BHI;
                shift_c = SHIFT_4;
                if (start_v) begin
                    state_d = ST_ERR;
                end else begin
                    clk_ena_c = 1'b1;
                    cnt_en    = 1'b1;
                    state_d   = (count == CNT_W'(1)) ? ST_MSB : ST_MID;
                end
            end
            ST_MSB: begin
                sel_c   = SEL_AHI_BHI;
                shift_c = SHIFT_8;
                if (start_v) begin
                    state_d = ST_ERR;
                end else begin
                    clk_ena_c = 1'b1;
                    state_d   = ST_CALC_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.input_sel = sel_c;
    assign bus.shift_sel = shift_c;
    assign bus.clk_ena   = clk_ena_c;
    assign bus.sclr_n    = sclr_n_c;
    assign bus.done      = done_c;
    assign bus.state_out = state_q;

endmodule

// File: tb/tb_mult8x8_controller.sv
// Bench for mult8x8_controller driving a behavioural nibble-multiplier datapath;
// products are scoreboarded against a*b computed at start time.
module tb_mult8x8_controller;
    import mult8x8_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult8x8_controller_if bus ();

    mult8x8_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Datapath: nibble mux, 4x4 multiplier, shifter, adder, accumulator
    logic [DW-1:0]     a_in;
    logic [DW-1:0]     b_in;
    logic [NIB_W-1:0]  a_nib;
    logic [NIB_W-1:0]  b_nib;
    logic [DW-1:0]     pp;
    logic [PROD_W-1:0] shifted;
    logic [PROD_W-1:0] acc;

    always_comb begin
        a_nib = bus.input_sel[0] ? a_in[7:4] : a_in[3:0];
        b_nib = bus.input_sel[1] ? b_in[7:4] : b_in[3:0];
        pp    = DW'(a_nib) * DW'(b_nib);
        case (bus.shift_sel)
            SHIFT_4: shifted = PROD_W'(pp) << 4;
            SHIFT_8: shifted = PROD_W'(pp) << 8;
            default: shifted = PROD_W'(pp);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!bus.sclr_n) acc <= '0;
        else if (bus.clk_ena) acc <= acc + shifted;
    end

    int checks   = 0;
    int failures = 0;
    logic [PROD_W-1:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b);
        logic [1:0]  es  [4];
        logic [1:0]  esh [4];
        logic [2:0]  est [4];
        logic [15:0] exp_p;
        int n;
        es  = '{2'b00, 2'b01, 2'b10, 2'b11};
        esh = '{2'b00, 2'b01, 2'b01, 2'b10};
        est = '{3'b001, 3'b010, 3'b010, 3'b011};
        a_in = a;
        b_in = b;
        bus.start = 1'b1;
        exp_q.push_back(16'(a) * 16'(b));
        #1;
        checks++;
        if (bus.sclr_n !== 1'b0 || bus.clk_ena !== 1'b1) begin
            failures++;
            $display("FAIL start_clear sclr_n=%b clk_ena=%b required 0/1", bus.sclr_n, bus.clk_ena);
        end
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({bus.input_sel, bus.shift_sel, bus.clk_ena, bus.state_out} !==
                {es[i], esh[i], 1'b1, est[i]}) begin
                failures++;
                $display("FAIL seq_cycle%0d sel=%b shift=%b ena=%b state=%b required %b/%b/1/%b",
                         i + 1, bus.input_sel, bus.shift_sel, bus.clk_ena, bus.state_out,
                         es[i], esh[i], est[i]);
            end
            step();
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.state_out !== 3'b100 || bus.clk_ena !== 1'b0 || n != 0) begin
            failures++;
            $display("FAIL done_cycle5 done=%b state=%b ena=%b late=%0d required 1/100/0/0",
                     bus.done, bus.state_out, bus.clk_ena, n);
        end
        exp_p = exp_q.pop_front();
        checks++;
        if (acc !== exp_p) begin
            failures++;
            $display("FAIL product a=%0d b=%0d got=%h required=%h", a, b, acc, exp_p);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        a_in = '0;
        b_in = '0;
        step();
        step();
        checks++;
        if ({bus.input_sel, bus.shift_sel, bus.clk_ena, bus.sclr_n, bus.done, bus.state_out}
            !== {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000}) begin
            failures++;
            $display("FAIL reset_held sel=%b shift=%b ena=%b sclr_n=%b done=%b state=%b required 00/00/0/1/0/000",
                     bus.input_sel, bus.shift_sel, bus.clk_ena, bus.sclr_n, bus.done, bus.state_out);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        step();
        checks++;
        if ({bus.input_sel, bus.shift_sel, bus.clk_ena, bus.sclr_n, bus.done, bus.state_out}
            !== {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'b000}) begin
            failures++;
            $display("FAIL reset_release sel=%b shift=%b ena=%b sclr_n=%b done=%b state=%b required 00/00/0/1/0/000",
                     bus.input_sel, bus.shift_sel, bus.clk_ena, bus.sclr_n, bus.done, bus.state_out);
        end
    endtask

    task automatic test_full_scale();
        run_mult(8'hFF, 8'hFF);
    endtask

    task automatic test_done_hold();
        run_mult(8'd12, 8'd13);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.done !== 1'b1 || bus.state_out !== 3'b100 || acc !== 16'd156) begin
                failures++;
                $display("FAIL done_hold%0d done=%b state=%b acc=%0d required 1/100/156",
                         i, bus.done, bus.state_out, acc);
            end
        end
    endtask

    task automatic test_error();
        logic [15:0] snap;
        a_in = 8'd5;
        b_in = 8'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        snap = acc;
        bus.start = 1'b1;
        #1;
        checks++;
        if (bus.clk_ena !== 1'b0 || bus.state_out !== 3'b010) begin
            failures++;
            $display("FAIL err_start_ena ena=%b state=%b required 0/010", bus.clk_ena, bus.state_out);
        end
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.state_out !== 3'b101 || bus.clk_ena !== 1'b0 || bus.done !== 1'b0 || acc !== snap) begin
                failures++;
                $display("FAIL err_state%0d state=%b ena=%b done=%b acc=%h required 101/0/0/%h",
                         i, bus.state_out, bus.clk_ena, bus.done, acc, snap);
            end
            step();
        end
        run_mult(8'd200, 8'd3);
    endtask

    task automatic test_back_to_back();
        checks++;
        if (bus.state_out !== 3'b100) begin
            failures++;
            $display("FAIL b2b_precond state=%b required 100", bus.state_out);
        end
        run_mult(8'd0, 8'd77);
    endtask

    task automatic test_reset_mid();
        a_in = 8'd9;
        b_in = 8'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.state_out !== 3'b011) begin
            failures++;
            $display("FAIL msb_reached state=%b required 011", bus.state_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.state_out !== 3'b000 || bus.clk_ena !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid state=%b ena=%b done=%b required 000/0/0",
                     bus.state_out, bus.clk_ena, bus.done);
        end
        step();
        reset = 1'b0;
        step();
        run_mult(8'd1, 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_scale();
        test_done_hold();
        test_error();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
